pipe_reg_mw: RTL

Parametrised Memory→Writeback pipeline register for the pipelined processor, sitting between the data-memory stage and the register-file write port. It replaces the plain always-latching MW register with one that supports asynchronous reset, hazard-unit stall and flush, a per-stage valid bit, and a selected writeback result. It also keeps saturating retired-instruction and bubble counters for performance measurement.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_reg_mw_sat_counter.sv | 32 +++
 rtl/pipe_reg_mw.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: control-word layout,
// bubble construction and default datapath widths.
package pipe_pkg;

    localparam int N_DEF  = 24;
    localparam int RA_DEF = 4;

    typedef struct packed {
        logic valid;
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } mw_ctrl_t;

    // A bubble carries no architectural side effects: nothing valid, no writes.
    function automatic mw_ctrl_t bubble_ctrl();
        mw_ctrl_t c;
        c.valid    = 1'b0;
        c.pcsrc    = 1'b0;
        c.regwrite = 1'b0;
        c.memtoreg = 1'b0;
        return c;
    endfunction

    // Side-effecting controls are qualified by the valid bit so an empty slot
    // can never write the register file or redirect the PC.
    function automatic mw_ctrl_t gate_ctrl(input logic valid, input logic pcsrc,
                                           input logic regwrite, input logic memtoreg);
        mw_ctrl_t c;
        c.valid    = valid;
        c.pcsrc    = pcsrc & valid;
        c.regwrite = regwrite & valid;
        c.memtoreg = memtoreg;
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_mw_sat_counter.sv
// Saturating event counter with synchronous clear and hold enable.
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic          en,
    output logic [CW-1:0] q
);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == {CW{1'b1}});
    assign q        = r_cnt;

    // Clear wins over everything; otherwise count enabled events, sticking at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (en && inc && !w_at_max) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/pipe_reg_mw.sv
// Memory->Writeback pipeline register with stall/flush, valid bit, writeback
// result select and saturating retired/bubble performance counters.
module pipe_reg_mw
    import pipe_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RA = RA_DEF,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          StallW,
    input  logic          FlushW,
    input  logic          CntClr,
    input  logic          ValidM,
    input  logic          PCSrcM,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic [N-1:0]  ReadDataM,
    input  logic [N-1:0]  ALUOutM,
    input  logic [RA-1:0] WA3M,
    output logic          ValidW,
    output logic          PCSrcW,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic [N-1:0]  ReadDataW,
    output logic [N-1:0]  ALUOutW,
    output logic [RA-1:0] WA3W,
    output logic [N-1:0]  ResultW,
    output logic [CW-1:0] RetiredCnt,
    output logic [CW-1:0] BubbleCnt
);

    mw_ctrl_t      r_ctrl;
    logic [N-1:0]  r_read_data;
    logic [N-1:0]  r_alu_out;
    logic [RA-1:0] r_wa3;

    logic w_cnt_en;
    logic w_ret_inc;
    logic w_bub_inc;

    // Counters advance on every edge that is not a pure stall; a flush counts
    // as a bubble even while stalled.
    assign w_cnt_en  = FlushW | ~StallW;
    assign w_ret_inc = ~FlushW & ValidM;
    assign w_bub_inc = FlushW | ~ValidM;

    // Stage register: flush inserts a bubble (data kept), stall holds, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl      <= bubble_ctrl();
            r_read_data <= {N{1'b0}};
            r_alu_out   <= {N{1'b0}};
            r_wa3       <= {RA{1'b0}};
        end else if (FlushW) begin
            r_ctrl      <= bubble_ctrl();
            r_read_data <= r_read_data;
            r_alu_out   <= r_alu_out;
            r_wa3       <= r_wa3;
        end else if (StallW) begin
            r_ctrl      <= r_ctrl;
            r_read_data <= r_read_data;
            r_alu_out   <= r_alu_out;
            r_wa3       <= r_wa3;
        end else begin
            r_ctrl      <= gate_ctrl(ValidM, PCSrcM, RegWriteM, MemtoRegM);
            r_read_data <= ReadDataM;
            r_alu_out   <= ALUOutM;
            r_wa3       <= WA3M;
        end
    end

    assign ValidW    = r_ctrl.valid;
    assign PCSrcW    = r_ctrl.pcsrc;
    assign RegWriteW = r_ctrl.regwrite;
    assign MemtoRegW = r_ctrl.memtoreg;
    assign ReadDataW = r_read_data;
    assign ALUOutW   = r_alu_out;
    assign WA3W      = r_wa3;

    // Writeback value depends only on W-stage registers.
    assign ResultW = r_ctrl.memtoreg ? r_read_data : r_alu_out;

    sat_counter #(.CW(CW)) u_retired_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_ret_inc),
        .en    (w_cnt_en),
        .q     (RetiredCnt)
    );

    sat_counter #(.CW(CW)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_bub_inc),
        .en    (w_cnt_en),
        .q     (BubbleCnt)
    );

endmodule
